// File: rtl/vclk_mode_sequencer.sv
// -----------------------------------------------------------------------------
// vclk_mode_sequencer
//
// Purpose:
//   Owns the video_mode select that drives the glitch-free video clock mux and
//   sequences every mode change so the video pipeline never sees a clock switch
//   while it is running:
//     1. wait for a frame boundary (vblank_start), bounded by WAIT_TIMEOUT,
//     2. hold the video pipeline in reset for PRE_CYCLES cycles,
//     3. flip video_mode while reset is held,
//     4. keep reset for SETTLE_CYCLES cycles while the new clock settles,
//     5. release reset and pulse done.
//   After reset the block also holds video_rst for SETTLE_CYCLES cycles so the
//   power-up clock can settle before the pipeline starts.
//
// Ports:
//   clk           system clock (single domain)
//   reset_n       synchronous active-low reset
//   req_mode      requested mode: 0 = 28.63636 MHz path, 1 = 25.175 MHz path
//   req_valid     request strobe, held with req_mode stable until accepted
//   req_ready     high only while idle; a request is taken on valid && ready
//   vblank_start  one-cycle frame-boundary pulse, already synchronous to clk
//   video_mode    registered select to the clock mux
//   video_rst     registered reset to the video pipeline
//   busy          high whenever the sequencer is not idle
//   done          one-cycle pulse when a request completes
//   timeout       sticky: last switch proceeded without seeing a vblank;
//                 cleared on the next accepted request
//
// Every output is a register. The handshake/status outputs are decoded from the
// next state, so they line up with the state register on the same edge.
// -----------------------------------------------------------------------------
module vclk_mode_sequencer #(
    parameter int PRE_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int WAIT_TIMEOUT  = 1048576,
    parameter int CNT_W         = 21
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req_mode,
    input  logic req_valid,
    output logic req_ready,
    input  logic vblank_start,
    output logic video_mode,
    output logic video_rst,
    output logic busy,
    output logic done,
    output logic timeout
);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WAIT_VB = 3'd2,
        ST_QUIESCE = 3'd3,
        ST_SWITCH  = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Terminal counts: a phase of N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PRE_LAST    = CNT_W'(PRE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_TIMEOUT - 1);

    // -------------------------------------------------------------------------
    // Output decode helpers (from the state being entered)
    // -------------------------------------------------------------------------

    // Pipeline reset is held during power-up settle and the whole switch window.
    function automatic logic f_rst_for(input state_t s);
        logic v;
        case (s)
            ST_INIT:    v = 1'b1;
            ST_QUIESCE: v = 1'b1;
            ST_SWITCH:  v = 1'b1;
            ST_IDLE:    v = 1'b0;
            ST_WAIT_VB: v = 1'b0;
            ST_DONE:    v = 1'b0;
            default:    v = 1'b1;
        endcase
        return v;
    endfunction

    // Idle is the only state that accepts requests and reports not busy.
    function automatic logic f_idle_for(input state_t s);
        logic v;
        case (s)
            ST_IDLE: v = 1'b1;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    // done is asserted exactly for the single cycle spent in DONE.
    function automatic logic f_done_for(input state_t s);
        logic v;
        case (s)
            ST_DONE: v = 1'b1;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    // -------------------------------------------------------------------------
    // Registers and next-state wires
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode_lat;
    logic             r_video_mode;
    logic             r_video_rst;
    logic             r_req_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_mode_lat_nxt;
    logic             w_video_mode_nxt;
    logic             w_timeout_nxt;

    // Next-state, counter and latched-data logic of the sequencer FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_inc        = r_cnt + CNT_ONE;
        w_cnt_nxt        = CNT_ZERO;
        w_mode_lat_nxt   = r_mode_lat;
        w_video_mode_nxt = r_video_mode;
        w_timeout_nxt    = r_timeout;

        case (r_state)
            ST_INIT: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end

            ST_IDLE: begin
                // r_req_ready is high in IDLE; gating with it keeps the
                // accept condition identical to what the requester observes.
                if (req_valid && r_req_ready) begin
                    w_mode_lat_nxt = req_mode;
                    w_timeout_nxt  = 1'b0;
                    w_cnt_nxt      = CNT_ZERO;
                    if (req_mode == r_video_mode) begin
                        // Nothing to switch: complete without touching reset.
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_WAIT_VB;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end

            ST_WAIT_VB: begin
                // A vblank in the terminal-count cycle wins: no timeout flag.
                if (vblank_start) begin
                    w_state_nxt = ST_QUIESCE;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == WAIT_LAST) begin
                    w_state_nxt   = ST_QUIESCE;
                    w_cnt_nxt     = CNT_ZERO;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt     = w_cnt_inc;
                end
            end

            ST_QUIESCE: begin
                if (r_cnt == PRE_LAST) begin
                    // The select flips on the same edge that enters SWITCH,
                    // so video_rst is already high when the mux sees it.
                    w_state_nxt      = ST_SWITCH;
                    w_cnt_nxt        = CNT_ZERO;
                    w_video_mode_nxt = r_mode_lat;
                end else begin
                    w_cnt_nxt        = w_cnt_inc;
                end
            end

            ST_SWITCH: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end

            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_INIT;
            r_cnt        <= CNT_ZERO;
            r_mode_lat   <= 1'b0;
            r_video_mode <= 1'b0;
            r_video_rst  <= 1'b1;
            r_req_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mode_lat   <= w_mode_lat_nxt;
            r_video_mode <= w_video_mode_nxt;
            r_video_rst  <= f_rst_for(w_state_nxt);
            r_req_ready  <= f_idle_for(w_state_nxt);
            r_busy       <= ~f_idle_for(w_state_nxt);
            r_done       <= f_done_for(w_state_nxt);
            r_timeout    <= w_timeout_nxt;
        end
    end

    assign video_mode = r_video_mode;
    assign video_rst  = r_video_rst;
    assign req_ready  = r_req_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_vclk_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vclk_mode_sequencer
//
// Self-checking bench for vclk_mode_sequencer (PRE=4, SETTLE=8, TIMEOUT=100).
// The reference is a timeline model: it keeps absolute edge numbers at which
// reset windows, the mode flip, done and readiness happen, and derives the
// expected outputs for every cycle from those timestamps.
// -----------------------------------------------------------------------------
module tb_vclk_mode_sequencer;

    localparam int P  = 4;
    localparam int S  = 8;
    localparam int WT = 100;

    logic clk          = 1'b0;
    logic reset_n      = 1'b0;
    logic req_mode     = 1'b0;
    logic req_valid    = 1'b0;
    logic vblank_start = 1'b0;
    logic req_ready;
    logic video_mode;
    logic video_rst;
    logic busy;
    logic done;
    logic timeout;

    int n_tests = 0;
    int n_fail  = 0;

    vclk_mode_sequencer #(
        .PRE_CYCLES    (P),
        .SETTLE_CYCLES (S),
        .WAIT_TIMEOUT  (WT),
        .CNT_W         (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_mode     (req_mode),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .vblank_start (vblank_start),
        .video_mode   (video_mode),
        .video_rst    (video_rst),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline reference model ----------------
    int   m_e         = 0;
    bit   m_valid     = 1'b0;
    bit   m_ready     = 1'b0;
    bit   m_waiting   = 1'b0;
    int   m_wait_start, m_init_end, m_idle_from;
    int   m_rst_from  = -1;
    int   m_rst_to    = -1;
    int   m_flip_at   = -1;
    int   m_done_at   = -1;
    bit   m_mode      = 1'b0;
    bit   m_target    = 1'b0;
    bit   m_timeout   = 1'b0;
    int   m_acc_cnt   = 0;
    bit   x_rst, x_done, x_ready;

    // Frame boundary (or give-up) decided at edge e: lay out the switch window.
    task automatic sched(input int e);
        m_waiting  = 1'b0;
        m_rst_from = e;
        m_flip_at  = e + P;
        m_rst_to   = e + P + S;
        m_done_at  = e + P + S;
        m_idle_from = e + P + S + 1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            m_e = m_e + 1;
            if (!reset_n) begin
                m_valid     = 1'b1;
                m_waiting   = 1'b0;
                m_mode      = 1'b0;
                m_timeout   = 1'b0;
                m_init_end  = m_e + S;
                m_idle_from = m_e + S;
                m_rst_from  = -1;
                m_rst_to    = -1;
                m_flip_at   = -1;
                m_done_at   = -1;
            end else if (m_valid) begin
                if (m_ready && req_valid) begin
                    m_acc_cnt = m_acc_cnt + 1;
                    m_timeout = 1'b0;
                    if (req_mode == m_mode) begin
                        m_done_at   = m_e;
                        m_idle_from = m_e + 1;
                    end else begin
                        m_waiting    = 1'b1;
                        m_wait_start = m_e;
                        m_target     = req_mode;
                    end
                end else if (m_waiting) begin
                    if (vblank_start) begin
                        sched(m_e);
                    end else if (m_e - 1 - m_wait_start == WT - 1) begin
                        m_timeout = 1'b1;
                        sched(m_e);
                    end
                end
            end
            if (m_valid) begin
                if (m_e == m_flip_at) m_mode = m_target;
                x_rst   = (m_e < m_init_end) || (m_e >= m_rst_from && m_e < m_rst_to);
                x_done  = (m_e == m_done_at);
                x_ready = !m_waiting && (m_e >= m_idle_from);
                m_ready = x_ready;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk1("video_rst",  video_rst,  x_rst);
                chk1("video_mode", video_mode, m_mode);
                chk1("done",       done,       x_done);
                chk1("req_ready",  req_ready,  x_ready);
                chk1("busy",       busy,       !x_ready);
                chk1("timeout",    timeout,    m_timeout);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic mode);
        int start;
        int cnt;
        start     = m_acc_cnt;
        cnt       = 0;
        req_valid = 1'b1;
        req_mode  = mode;
        do begin
            @(negedge clk);
            cnt++;
        end while (m_acc_cnt == start && cnt < 500);
        req_valid = 1'b0;
        if (m_acc_cnt == start) chki("accept_bound", 0, 1);
    endtask

    task automatic wait_done();
        int cnt;
        cnt = 0;
        while (done !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        chk1("done_bound", done, 1'b1);
    endtask

    // Called at a negedge just after a reset edge: releases reset and pins
    // the power-up settle window.
    task automatic release_and_check_init();
        reset_n = 1'b1;
        chk1("init_rst0", video_rst, 1'b1);
        repeat (S - 1) begin
            @(negedge clk);
            chk1("init_rst_hold", video_rst, 1'b1);
        end
        @(negedge clk);
        chk1("init_rst_rel",   video_rst,  1'b0);
        chk1("init_ready",     req_ready,  1'b1);
        chk1("init_busy",      busy,       1'b0);
        chk1("init_mode",      video_mode, 1'b0);
    endtask

    int pcts [4] = '{0, 3, 20, 60};

    initial begin
        int cnt;
        int done_seen;
        int last;
        int pct;

        // Power-up
        repeat (3) @(negedge clk);
        chk1("rst_busy",  busy,      1'b1);
        chk1("rst_ready", req_ready, 1'b0);
        release_and_check_init();

        // Mode 0 -> 1 with a vblank in wait cycle 9
        issue(1'b1);
        repeat (9) @(negedge clk);
        vblank_start = 1'b1;
        @(negedge clk);
        vblank_start = 1'b0;
        chk1("vb_rst_rise", video_rst,  1'b1);
        chk1("vb_mode_old", video_mode, 1'b0);
        repeat (P - 1) @(negedge clk);
        chk1("vb_mode_pre", video_mode, 1'b0);
        @(negedge clk);
        chk1("vb_mode_new", video_mode, 1'b1);
        repeat (S - 1) @(negedge clk);
        chk1("vb_rst_hold", video_rst,  1'b1);
        @(negedge clk);
        chk1("vb_rst_fall", video_rst,  1'b0);
        chk1("vb_done",     done,       1'b1);
        chk1("vb_timeout",  timeout,    1'b0);
        @(negedge clk);
        chk1("vb_done_end", done,       1'b0);
        chk1("vb_ready",    req_ready,  1'b1);

        // Same-mode request
        issue(1'b1);
        chk1("same_done", done,      1'b1);
        chk1("same_busy", busy,      1'b1);
        chk1("same_rst",  video_rst, 1'b0);
        @(negedge clk);
        chk1("same_done_end", done, 1'b0);
        chk1("same_busy_end", busy, 1'b0);

        // Mode 1 -> 0 with no vblank: times out after WT wait cycles
        issue(1'b0);
        cnt = 0;
        while (video_rst === 1'b0 && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        chki("to_wait_cycles", cnt, WT);
        wait_done();
        chk1("to_timeout", timeout,    1'b1);
        chk1("to_mode",    video_mode, 1'b0);
        @(negedge clk);
        issue(1'b0);
        chk1("to_cleared", timeout, 1'b0);
        @(negedge clk);

        // Request held during an ongoing switch
        issue(1'b1);
        req_valid = 1'b1;
        req_mode  = 1'b0;
        last      = m_acc_cnt;
        done_seen = 0;
        cnt       = 0;
        while (m_acc_cnt == last && cnt < 600) begin
            vblank_start = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            if (done === 1'b1) done_seen++;
            cnt++;
        end
        req_valid    = 1'b0;
        vblank_start = 1'b0;
        chki("held_done_count", done_seen, 1);
        repeat (3) @(negedge clk);
        vblank_start = 1'b1;
        @(negedge clk);
        vblank_start = 1'b0;
        wait_done();
        chk1("held_mode", video_mode, 1'b0);
        @(negedge clk);

        // Reset during SWITCH
        issue(1'b1);
        vblank_start = 1'b1;
        @(negedge clk);
        vblank_start = 1'b0;
        repeat (P + 2) @(negedge clk);
        chk1("sw_mode_set", video_mode, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        chk1("sw_rst_mode",  video_mode, 1'b0);
        chk1("sw_rst_rst",   video_rst,  1'b1);
        chk1("sw_rst_ready", req_ready,  1'b0);
        chk1("sw_rst_busy",  busy,       1'b1);
        chk1("sw_rst_done",  done,       1'b0);
        release_and_check_init();

        // Randomized traffic with varying vblank density and random resets
        last = m_acc_cnt;
        pct  = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) pct = pcts[(c / 300) % 4];
            @(negedge clk);
            if (m_acc_cnt != last) begin
                req_valid = 1'b0;
                last      = m_acc_cnt;
            end
            vblank_start = (pct != 0) && ($urandom_range(0, 99) < pct);
            if (!req_valid && $urandom_range(0, 5) == 0) begin
                req_valid = 1'b1;
                req_mode  = 1'($urandom_range(0, 1));
            end
            if (reset_n == 1'b0) reset_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
        end
        req_valid    = 1'b0;
        vblank_start = 1'b0;
        reset_n      = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
